// File: rtl/val2_pkg.sv
// Shared definitions for the Val2 shifter pipeline: shift types, operand kinds
// and the width of the normalised shift-amount field.
package val2_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    K_ROT_IMM,
    K_SH_IMM,
    K_SH_REG,
    K_MEM_IMM
  } kind_e;

  // The amount field must be able to hold DATA_LEN itself ("shift by full width").
  function automatic int amt_w(input int data_len);
    return $clog2(data_len) + 1;
  endfunction

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter on a normalised request. An amount of 0 means
// "pass the operand through", except for RRX, and amounts never exceed DATA_LEN.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int AW       = amt_w(DATA_LEN)
) (
  input  kind_e               kind,
  input  logic [1:0]          sh_type,
  input  logic [AW-1:0]       amt,
  input  logic [DATA_LEN-1:0] rm,
  input  logic                c_in,
  output logic [DATA_LEN-1:0] val2,
  output logic                c_out
);

  logic        [DATA_LEN:0]     lsl_w;
  logic        [DATA_LEN:0]     lsr_w;
  logic signed [DATA_LEN:0]     asr_w;
  logic        [2*DATA_LEN-1:0] ror_w;

  // An extra guard bit on the shifted-out side catches the carry, so
  // a shift by exactly DATA_LEN falls out of the same datapath.
  always_comb begin
    lsl_w = {1'b0, rm} << amt;
    lsr_w = {rm, 1'b0} >> amt;
    asr_w = $signed({rm, 1'b0}) >>> amt;
    ror_w = {rm, rm} >> amt;
    val2  = rm;
    c_out = c_in;
    if (amt == '0) begin
      if (kind == K_SH_IMM && sh_type == SH_ROR) begin
        val2  = {c_in, rm[DATA_LEN-1:1]};
        c_out = rm[0];
      end
    end else begin
      case (sh_type)
        SH_LSL: begin
          val2  = lsl_w[DATA_LEN-1:0];
          c_out = lsl_w[DATA_LEN];
        end
        SH_LSR: begin
          val2  = lsr_w[DATA_LEN:1];
          c_out = lsr_w[0];
        end
        SH_ASR: begin
          val2  = asr_w[DATA_LEN:1];
          c_out = asr_w[0];
        end
        default: begin
          val2  = ror_w[DATA_LEN-1:0];
          c_out = ror_w[DATA_LEN-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shifter_pipe.sv
// Two-stage Val2 generator: stage 1 decodes and normalises the operand class,
// stage 2 shifts. Valid/ready handshake with backpressure and synchronous flush.
module val2_shifter_pipe
  import val2_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                imm,
  input  logic                mem,
  input  logic [11:0]         offset,
  input  logic [DATA_LEN-1:0] Val_Rm,
  input  logic [7:0]          Val_Rs,
  input  logic                c_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] val2,
  output logic                shifter_c_out
);

  localparam int            AW       = amt_w(DATA_LEN);
  localparam logic [AW-1:0] AMT_FULL = AW'(DATA_LEN);

  kind_e               dec_kind;
  logic [1:0]          dec_type;
  logic [AW-1:0]       dec_amt;
  logic [DATA_LEN-1:0] dec_opnd;
  logic [AW-1:0]       rs_mod;
  logic                rs_big, rs_over;

  logic                s1_valid_q, s1_valid_d;
  kind_e               s1_kind_q, s1_kind_d;
  logic [1:0]          s1_type_q, s1_type_d;
  logic [AW-1:0]       s1_amt_q, s1_amt_d;
  logic [DATA_LEN-1:0] s1_opnd_q, s1_opnd_d;
  logic                s1_c_q, s1_c_d;

  logic                s2_valid_q, s2_valid_d;
  logic [DATA_LEN-1:0] val2_q, val2_d;
  logic                c2_q, c2_d;

  logic                s2_adv, s1_load, s2_load;
  logic [DATA_LEN-1:0] core_val;
  logic                core_c;

  // Register-specified amounts are folded into 0..DATA_LEN; over-long
  // LSL/LSR become a full-width shift of zero so the carry also reads 0.
  always_comb begin
    rs_mod   = AW'(int'(Val_Rs) & (DATA_LEN - 1));
    rs_big   = int'(Val_Rs) >= DATA_LEN;
    rs_over  = int'(Val_Rs) > DATA_LEN;
    dec_type = offset[6:5];
    dec_amt  = '0;
    dec_opnd = Val_Rm;
    if (mem)           dec_kind = imm ? K_SH_IMM : K_MEM_IMM;
    else if (imm)      dec_kind = K_ROT_IMM;
    else if (offset[4]) dec_kind = K_SH_REG;
    else               dec_kind = K_SH_IMM;
    case (dec_kind)
      K_ROT_IMM: begin
        dec_type = SH_ROR;
        dec_amt  = AW'({offset[11:8], 1'b0});
        dec_opnd = DATA_LEN'(offset[7:0]);
      end
      K_MEM_IMM: dec_opnd = DATA_LEN'(offset);
      K_SH_IMM: begin
        dec_amt = AW'(offset[11:7]);
        if (offset[11:7] == '0 && (dec_type == SH_LSR || dec_type == SH_ASR))
          dec_amt = AMT_FULL;
      end
      default: begin
        if (Val_Rs == '0) begin
          dec_amt = '0;
        end else if (dec_type == SH_ROR) begin
          dec_amt = (rs_mod == '0) ? AMT_FULL : rs_mod;
        end else if (rs_big) begin
          dec_amt = AMT_FULL;
          if (rs_over && dec_type != SH_ASR) dec_opnd = '0;
        end else begin
          dec_amt = AW'(Val_Rs);
        end
      end
    endcase
  end

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    s1_load    = in_valid && in_ready && !flush;
    s2_load    = s2_adv && s1_valid_q;
    s1_valid_d = flush ? 1'b0 : (in_ready ? in_valid : s1_valid_q);
    s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
    s1_kind_d  = s1_load ? dec_kind : s1_kind_q;
    s1_type_d  = s1_load ? dec_type : s1_type_q;
    s1_amt_d   = s1_load ? dec_amt  : s1_amt_q;
    s1_opnd_d  = s1_load ? dec_opnd : s1_opnd_q;
    s1_c_d     = s1_load ? c_in     : s1_c_q;
    val2_d     = s2_load ? core_val : val2_q;
    c2_d       = s2_load ? core_c   : c2_q;
  end

  val2_shift_core #(.DATA_LEN(DATA_LEN), .AW(AW)) u_core (
    .kind    (s1_kind_q),
    .sh_type (s1_type_q),
    .amt     (s1_amt_q),
    .rm      (s1_opnd_q),
    .c_in    (s1_c_q),
    .val2    (core_val),
    .c_out   (core_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= K_ROT_IMM;
      s1_type_q  <= SH_LSL;
      s1_amt_q   <= '0;
      s1_opnd_q  <= '0;
      s1_c_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      val2_q     <= '0;
      c2_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_kind_q  <= s1_kind_d;
      s1_type_q  <= s1_type_d;
      s1_amt_q   <= s1_amt_d;
      s1_opnd_q  <= s1_opnd_d;
      s1_c_q     <= s1_c_d;
      s2_valid_q <= s2_valid_d;
      val2_q     <= val2_d;
      c2_q       <= c2_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign val2          = val2_q;
  assign shifter_c_out = c2_q;

endmodule

// File: tb/tb_val2_shifter_pipe.sv
// Bench for val2_shifter_pipe: directed ARM shifter cases plus a randomized
// stream with backpressure and flush, checked against a bit-serial reference.
module tb_val2_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        imm = 1'b0, mem = 1'b0;
  logic [11:0] offset = '0;
  logic [31:0] Val_Rm = '0;
  logic [7:0]  Val_Rs = '0;
  logic        c_in = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] val2;
  logic        shifter_c_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        imm, mem;
    logic [11:0] offset;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        cin;
  } req_t;

  val2_shifter_pipe #(.DATA_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mem(mem), .offset(offset), .Val_Rm(Val_Rm), .Val_Rs(Val_Rs),
    .c_in(c_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .val2(val2), .shifter_c_out(shifter_c_out)
  );

  always #5 clk = ~clk;

  // Reference: applies the shift one bit at a time, carry = last bit out.
  function automatic logic [32:0] model(input req_t r);
    logic [31:0] v;
    logic        c;
    int          n;
    logic [1:0]  t;
    v = r.rm; c = r.cin; t = r.offset[6:5];
    if (r.mem && !r.imm) return {r.cin, 20'h0, r.offset};
    if (!r.mem && r.imm) begin
      v = {24'h0, r.offset[7:0]};
      n = 2 * int'(r.offset[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      c = (n == 0) ? r.cin : v[31];
      return {c, v};
    end
    if (r.mem || !r.offset[4]) begin
      n = int'(r.offset[11:7]);
      if (n == 0) begin
        case (t)
          2'd0: return {r.cin, r.rm};
          2'd1: return {r.rm[31], 32'h0};
          2'd2: return {r.rm[31], {32{r.rm[31]}}};
          default: return {r.rm[0], r.cin, r.rm[31:1]};
        endcase
      end
    end else begin
      n = int'(r.rs);
      if (n == 0) return {r.cin, r.rm};
      if (t < 2 && n > 32) return 33'h0;
      if (t == 2 && n > 32) n = 32;
    end
    for (int i = 0; i < n; i++) begin
      case (t)
        2'd0: begin c = v[31]; v = v << 1; end
        2'd1: begin c = v[0];  v = v >> 1; end
        2'd2: begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  function automatic req_t mk(input logic i, input logic m, input logic [11:0] o,
                              input logic [31:0] rm, input logic [7:0] rs, input logic ci);
    req_t r;
    r.imm = i; r.mem = m; r.offset = o; r.rm = rm; r.rs = rs; r.cin = ci;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.imm = 1'($urandom); r.mem = 1'($urandom); r.offset = 12'($urandom);
    r.rm = $urandom; r.cin = 1'($urandom);
    case ($urandom_range(0, 5))
      0: r.rs = 8'd0;
      1: r.rs = 8'd32;
      2: r.rs = 8'd33;
      3: r.rs = 8'd64;
      4: r.rs = 8'($urandom_range(1, 31));
      default: r.rs = 8'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) r.offset[11:7] = 5'd0;
    return r;
  endfunction

  task automatic drive(input req_t r);
    imm = r.imm; mem = r.mem; offset = r.offset; Val_Rm = r.rm; Val_Rs = r.rs; c_in = r.cin;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (out_valid !== 1'b0 || val2 !== 32'h0 || shifter_c_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b val2=%h c=%b, want 0/0/0", out_valid, val2, shifter_c_out);
    end
    #9 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    req_t        rv[10];
    logic [31:0] ev[10];
    logic        ec[10];
    rv[0] = mk(1, 0, 12'h4FF, 32'h0, 8'd0, 0);         ev[0] = 32'hFF000000; ec[0] = 1;
    rv[1] = mk(0, 0, 12'h020, 32'h80000001, 8'd0, 0);  ev[1] = 32'h0;        ec[1] = 1;
    rv[2] = mk(0, 0, 12'h040, 32'h80000001, 8'd0, 0);  ev[2] = 32'hFFFFFFFF; ec[2] = 1;
    rv[3] = mk(0, 0, 12'h060, 32'h00000003, 8'd0, 1);  ev[3] = 32'h80000001; ec[3] = 1;
    rv[4] = mk(0, 0, 12'h010, 32'hFFFFFFFF, 8'd32, 0); ev[4] = 32'h0;        ec[4] = 1;
    rv[5] = mk(0, 0, 12'h010, 32'hFFFFFFFF, 8'd33, 1); ev[5] = 32'h0;        ec[5] = 0;
    rv[6] = mk(0, 0, 12'h010, 32'hFFFFFFFF, 8'd0, 1);  ev[6] = 32'hFFFFFFFF; ec[6] = 1;
    rv[7] = mk(0, 0, 12'h070, 32'hFFFFFFFF, 8'd64, 0); ev[7] = 32'hFFFFFFFF; ec[7] = 1;
    rv[8] = mk(0, 1, 12'hFFF, 32'h12345678, 8'd5, 1);  ev[8] = 32'h00000FFF; ec[8] = 1;
    rv[9] = mk(0, 1, 12'hFFF, 32'h12345678, 8'd5, 0);  ev[9] = 32'h00000FFF; ec[9] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(rv[i]); in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_accept: got in_ready=%b out_valid=%b, want 1/0", i, in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_early: got out_valid=%b one edge after accept, want 0", i, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || val2 !== ev[i] || shifter_c_out !== ec[i]) begin
        n_err++;
        $display("FAIL dir%0d_result: got v=%b val2=%h c=%b, want 1 %h %b",
                 i, out_valid, val2, shifter_c_out, ev[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    req_t        r[4];
    logic [32:0] q[$];
    logic [32:0] e, snap;
    int          idx = 0, got = 0;
    for (int i = 0; i < 4; i++) r[i] = rand_req();
    snap = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) drive(r[idx]);
      @(negedge clk);
      if (cyc == 2) snap = {shifter_c_out, val2};
      if (cyc == 3 || cyc == 4) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {shifter_c_out, val2} !== snap) begin
          n_err++;
          $display("FAIL bp_hold: got in_ready=%b v=%b out=%h, want 0 1 %h",
                   in_ready, out_valid, {shifter_c_out, val2}, snap);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        e = (q.size() > 0) ? q.pop_front() : 33'h0;
        if ({shifter_c_out, val2} !== e) begin
          n_err++;
          $display("FAIL bp_result%0d: got %h, want %h", got, {shifter_c_out, val2}, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(r[idx]));
        idx++;
      end
    end
    n_vec++;
    if (got != 4) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, want 4", got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    req_t a, b, c, d;
    int   got = 0;
    bit   acc = 0;
    a = rand_req(); b = rand_req(); c = rand_req(); d = rand_req();
    @(posedge clk); #1;
    drive(a); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    drive(b);
    @(posedge clk); #1;
    drive(c); flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_full: got out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; drive(d); out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_kill: got out_valid=%b after flush, want 0", out_valid);
    end
    if (in_valid && in_ready) acc = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        got++;
        n_vec++;
        if ({shifter_c_out, val2} !== model(d) || got > 1) begin
          n_err++;
          $display("FAIL flush_next: got %h (#%0d), want single %h", {shifter_c_out, val2}, got, model(d));
        end
      end
      if (in_valid && in_ready) acc = 1;
    end
    n_vec++;
    if (got != 1) begin
      n_err++;
      $display("FAIL flush_count: got %0d results, want 1", got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random(input int ncyc);
    req_t        cur;
    logic [32:0] q[$];
    logic [32:0] e;
    cur = rand_req();
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      drive(cur);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        e = (q.size() > 0) ? q.pop_front() : 33'h0;
        if ({shifter_c_out, val2} !== e) begin
          n_err++;
          $display("FAIL rnd_result: cyc %0d got %h, want %h", i, {shifter_c_out, val2}, e);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(model(cur));
        cur = rand_req();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n_vec++;
        e = (q.size() > 0) ? q.pop_front() : 33'h0;
        if ({shifter_c_out, val2} !== e) begin
          n_err++;
          $display("FAIL rnd_drain: got %h, want %h", {shifter_c_out, val2}, e);
        end
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_lost: %0d results outstanding, want 0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(rand_req()); in_valid = 1'b1;
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy: got out_valid=%b before reset, want 1", out_valid);
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || val2 !== 32'h0 || shifter_c_out !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_outputs: got v=%b val2=%h c=%b rdy=%b, want 0 0 0 1",
               out_valid, val2, shifter_c_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_pulse: got out_valid=%b %0d cycles after reset, want 0", out_valid, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random(3000);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
